// File: rtl/qsort_pkg.sv
// rtl/qsort_pkg.sv - shared quicksort types and sizing constants
// State encoding is common to the unloader and the sorter controller.
package qsort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CAPT  = 2'd2,
    DRAIN = 2'd3
  } qsort_state_e;

  localparam int DEF_N = 8;
  localparam int DEF_W = 32;

  // Counters must hold the value N itself, not just N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/qsort_unloader_buf.sv
// rtl/qsort_unloader_buf.sv - N x W capture buffer, one write port, one read port
// Contents are don't-care after reset, so the array carries no reset.
module qsort_unloader_buf
  import qsort_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qsort_unloader.sv
// rtl/qsort_unloader.sv - reads sorted words out of the sorter, checks order, streams them out
// Strobe, delayed capture and order check live here; storage is in qsort_unloader_buf.
module qsort_unloader
  import qsort_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         qcomp_i,
  output logic         write_o,
  input  logic [W-1:0] xout_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic         m_last_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         order_err_o,
  output logic         overrun_o
);

  localparam int CW = cnt_width(N);
  localparam int AW = $clog2(N);

  qsort_state_e state, state_nxt;

  logic          qcomp_q, rise_q;
  logic [CW-1:0] wr_cnt, cap_cnt;
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  prev, rdata;
  logic          cap_en, start, wr_last, last_cap, rd_last, hs;

  assign start    = (state == IDLE) && rise_q;
  assign wr_last  = (wr_cnt == CW'(N - 1));
  assign last_cap = cap_en && (cap_cnt == CW'(N - 1));
  assign rd_last  = (rd_idx == AW'(N - 1));
  assign hs       = m_valid_o && m_ready_i;

  // The strobe delayed by the sorter's read latency marks valid words on xout_i.
  generate
    if (RD_LAT == 0) begin : g_no_dly
      assign cap_en = write_o;
    end else begin : g_dly
      logic [RD_LAT-1:0] dly;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= (dly << 1) | RD_LAT'(write_o);
      end
      assign cap_en = dly[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    write_o   = 1'b0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = '0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE:  if (rise_q) state_nxt = REQ;
      REQ: begin
        write_o = 1'b1;
        // With zero latency the last word lands as the strobe ends; skip CAPT.
        if (wr_last) state_nxt = last_cap ? DRAIN : CAPT;
      end
      CAPT:  if (last_cap) state_nxt = DRAIN;
      DRAIN: begin
        m_valid_o = 1'b1;
        m_data_o  = rdata;
        m_last_o  = rd_last;
        if (m_ready_i && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcomp_q     <= 1'b0;
      rise_q      <= 1'b0;
      wr_cnt      <= '0;
      cap_cnt     <= '0;
      rd_idx      <= '0;
      prev        <= '0;
      done_o      <= 1'b0;
      order_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      qcomp_q <= qcomp_i;
      rise_q  <= qcomp_i & ~qcomp_q;
      done_o  <= hs && rd_last;
      if (rise_q && state != IDLE) overrun_o <= 1'b1;
      if (start) begin
        wr_cnt      <= '0;
        cap_cnt     <= '0;
        rd_idx      <= '0;
        order_err_o <= 1'b0;
      end else begin
        if (write_o) wr_cnt <= wr_cnt + 1'b1;
        if (cap_en) begin
          cap_cnt <= cap_cnt + 1'b1;
          prev    <= xout_i;
          if (cap_cnt != '0 && xout_i < prev) order_err_o <= 1'b1;
        end
        if (hs) rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      end
    end
  end

  qsort_unloader_buf #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_buf (
    .clk   (clk),
    .we    (cap_en),
    .waddr (cap_cnt[AW-1:0]),
    .wdata (xout_i),
    .raddr (rd_idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_qsort_unloader.sv
// tb/tb_qsort_unloader.sv - bench for qsort_unloader at read latencies 0, 1 and 3
// A sorter model per instance feeds xout; a scoreboard per instance checks the stream.
module tb_qsort_unloader;

  localparam int N = 8;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         qcomp;
  logic         m_ready;
  logic         run_start;
  logic         end_chk;
  logic         ready_rnd;
  logic         exp_err;
  logic         exp_ovr;
  logic [W-1:0] words [N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = ready_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    logic         write_o, m_valid, m_last, busy, done, order_err, overrun;
    logic [W-1:0] xout, m_data, prev_data;
    logic [38:0]  outs;
    int           el, hs, wr, dn, vcyc, first_v;
    bit           fin, prev_stall;

    assign outs = {write_o, m_valid, m_last, m_data, busy, done, order_err, overrun};

    qsort_unloader #(.N(N), .W(W), .RD_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .qcomp_i     (qcomp),
      .write_o     (write_o),
      .xout_i      (xout),
      .m_valid_o   (m_valid),
      .m_ready_i   (m_ready),
      .m_data_o    (m_data),
      .m_last_o    (m_last),
      .busy_o      (busy),
      .done_o      (done),
      .order_err_o (order_err),
      .overrun_o   (overrun)
    );

    initial begin
      el = -1; hs = 0; wr = 0; dn = 0; vcyc = 0; first_v = -1;
      fin = 0; prev_stall = 0; prev_data = '0; xout = '0;
      forever begin
        @(negedge clk);
        if (run_start) begin
          el = -1; hs = 0; wr = 0; dn = 0; vcyc = 0; first_v = -1;
          fin = 0; prev_stall = 0;
        end
        // Sorter: word k appears LAT cycles after the k-th strobe cycle, noise otherwise.
        if (el >= 0) el++;
        else if (rst_n && write_o) el = 0;
        xout = (el >= LAT && el < LAT + N) ? words[el-LAT] : W'($urandom);
        if (!rst_n) prev_stall = 0;
        if (rst_n && !run_start) begin
          if (write_o) wr++;
          if (prev_stall) begin
            check($sformatf("valid_hold%0d", g), m_valid, 1);
            check($sformatf("stall_data%0d", g), m_data, prev_data);
          end
          if (m_valid) begin
            vcyc++;
            if (first_v < 0) begin
              first_v = el;
              check($sformatf("first_valid%0d", g), el, N + LAT);
            end
            if (m_ready) begin
              if (hs < N) begin
                check($sformatf("data%0d_%0d", g, hs), m_data, words[hs]);
                check($sformatf("last%0d_%0d", g, hs), m_last, hs == N - 1);
              end else begin
                check($sformatf("extra_hs%0d", g), hs, N - 1);
              end
              hs++;
            end
            prev_stall = !m_ready;
            prev_data  = m_data;
          end
          if (done) begin
            dn++;
            fin = 1;
            check($sformatf("done_hs%0d", g), hs, N);
          end
        end
        if (end_chk) begin
          check($sformatf("write_cycles%0d", g), wr, N);
          check($sformatf("done_pulses%0d", g), dn, 1);
          check($sformatf("handshakes%0d", g), hs, N);
          check($sformatf("order_err%0d", g), order_err, exp_err);
          check($sformatf("overrun%0d", g), overrun, exp_ovr);
          check($sformatf("busy_end%0d", g), busy, 0);
          if (!ready_rnd) check($sformatf("drain_cycles%0d", g), vcyc, N);
        end
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    check({tag, "0"}, g_dut[0].outs, 0);
    check({tag, "1"}, g_dut[1].outs, 0);
    check({tag, "3"}, g_dut[2].outs, 0);
  endtask

  task automatic start_run(input bit hold, input bit again, input bit rnd);
    ready_rnd = rnd;
    exp_err   = 1'b0;
    for (int k = 1; k < N; k++) if (words[k] < words[k-1]) exp_err = 1'b1;
    @(posedge clk); #1 run_start = 1'b1;
    @(posedge clk); #1 run_start = 1'b0; qcomp = 1'b1;
    @(posedge clk); @(negedge clk);
    check("write_early", g_dut[1].write_o, 0);
    @(posedge clk); @(negedge clk);
    check("write_first", g_dut[1].write_o, 1);
    check("err_cleared", g_dut[1].order_err, 0);
    if (!hold) qcomp = 1'b0;
    if (again) begin
      repeat (2) @(negedge clk);
      qcomp   = 1'b1;
      exp_ovr = 1'b1;
      @(negedge clk);
      qcomp = 1'b0;
    end
  endtask

  task automatic finish_run;
    bit all_fin;
    all_fin = 0;
    for (int c = 0; c < 400 && !all_fin; c++) begin
      @(negedge clk);
      all_fin = g_dut[0].fin && g_dut[1].fin && g_dut[2].fin;
    end
    check("run_timeout", all_fin, 1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 end_chk = 1'b1;
    @(posedge clk); #1 end_chk = 1'b0; qcomp = 1'b0;
  endtask

  task automatic rand_words(input bit sorted);
    logic [W-1:0] q [$];
    q = {};
    for (int k = 0; k < N; k++) q.push_back(W'($urandom_range(0, 40)));
    if (sorted) q.sort();
    for (int k = 0; k < N; k++) words[k] = q[k];
  endtask

  initial begin
    rst_n = 1'b0; qcomp = 1'b0; run_start = 1'b0; end_chk = 1'b0;
    ready_rnd = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0;
    for (int k = 0; k < N; k++) words[k] = '0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outs");
    rst_n = 1'b1;

    words = '{1, 2, 3, 8, 12, 13, 22, 31};
    start_run(0, 0, 0); finish_run();
    words = '{1, 2, 8, 3, 15, 20, 25, 30};
    start_run(0, 0, 0); finish_run();
    words = '{1, 2, 3, 8, 12, 13, 22, 31};
    start_run(0, 0, 0); finish_run();
    words = '{5, 5, 5, 5, 7, 7, 9, 9};
    start_run(0, 0, 1); finish_run();
    rand_words(1);
    start_run(0, 1, 0); finish_run();
    rand_words(1);
    start_run(1, 0, 1); finish_run();
    for (int r = 0; r < 4; r++) begin
      rand_words(r % 2 == 0);
      start_run(0, 0, 1); finish_run();
    end

    rand_words(1);
    start_run(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("write_4th", g_dut[1].write_o, 1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("abort_outs");
    exp_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_outs_zero("post_abort");
    words = '{3, 4, 4, 10, 11, 19, 27, 40};
    start_run(0, 0, 1); finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qsort_unloader.md
# qsort_unloader

Result-side companion to the quicksort engine: the counterpart of the serial load stream that fills the sorter. After the sorter raises `Qcomp`, this block asserts the sorter's `write` strobe, captures the N sorted words from `xout` into a local buffer, and checks that they are non-decreasing. It then streams them to a downstream consumer over a valid/ready interface. It sits between the sorter's output port and the system sink, and also serves as a self-checking monitor in the sorter bench.

## Interface
- `N`, 8: number of words per sort run (≥2, power of two not required)
- `W`, 32: word width
- `RD_LAT`, 1: cycles from `write_o` rising edge to first valid word on `xout_i` (0..3)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `qcomp_i` input 1: sorter completion flag; only its rising edge is used
- `write_o` output 1: read-out strobe to sorter (its `write` input)
- `xout_i` input W: sorter serial output, one word per cycle while streaming
- `m_valid_o` output 1: downstream word valid
- `m_ready_i` input 1: downstream ready
- `m_data_o` output W: downstream word
- `m_last_o` output 1: high with word N-1
- `busy_o` output 1: high in any state other than IDLE
- `done_o` output 1: one-cycle pulse after the last downstream handshake
- `order_err_o` output 1: sticky; set if any captured word < its predecessor (unsigned); cleared at next run start
- `overrun_o` output 1: sticky; `qcomp_i` rose while not IDLE; cleared only by reset

## Operation
- States: IDLE, REQ, CAPT, DRAIN.
- IDLE: on `qcomp_i` rising edge (registered edge detect, previous value reset to 0) go to REQ, clear `order_err_o`, and zero the word counters.
- REQ: `write_o`=1 for exactly N consecutive cycles (counter 0..N-1), then `write_o`=0. A delay line of depth RD_LAT on the strobe produces a capture enable. Capture runs concurrently with REQ. The state moves to CAPT when the strobe ends, unless all N words are already captured.
- CAPT: wait until the capture count reaches N, then go to DRAIN.
- Capture: word k is stored into `buf[k]`. For k≥1, compare against `buf[k-1]`, held in a prev register. If smaller, set `order_err_o`. Equal values are legal.
- DRAIN: `m_data_o`=`buf[rd]`, `m_valid_o`=1, `m_last_o`=(rd==N-1). On `m_valid_o && m_ready_i`, increment rd. The last handshake pulses `done_o` on the next cycle and returns to IDLE.
- Data is not modified. `order_err_o` is status only; streaming proceeds regardless.
- `qcomp_i` rising in REQ/CAPT/DRAIN: ignored for sequencing, sets `overrun_o`.
- `qcomp_i` held high across the return to IDLE: no new run without a fresh rising edge.

## Timing
- Reset (async, immediate): state IDLE. All outputs 0: `write_o`, `m_valid_o`, `m_last_o`, `m_data_o`, `busy_o`, `done_o`, `order_err_o`, `overrun_o`. Counters, delay line and edge-detect register are 0. Buffer contents are don't-care.
- Reset mid-run: run abandoned. `write_o` drops in the same instant. No `done_o` is produced.
- `write_o` first high in the cycle after the edge-detect cycle, i.e. 2 edges after `qcomp_i` is sampled high.
- Word k is captured at the edge ending cycle (first write cycle + k + RD_LAT).
- First `m_valid_o` occurs 1 cycle after the last capture. With `m_ready_i` tied high, the drain takes N cycles.
- `m_valid_o` is never deasserted without a handshake. `m_data_o` is stable while stalled.
- Minimum run-to-run: 2 + N + RD_LAT + 1 + N cycles.

## Structure
- A shared `qsort_pkg` holds:
  - the state enum, used by this block and the sorter controller;
  - default `N`/`W` constants;
  - a `clog2`-based counter-width constant sized for N.
- Sub-module `qsort_unloader_buf`: an N×W register array with a write-port and read-port index. The rest (FSM, delay line, order check) stays in the top block.
- Estimated 150–250 lines RTL.

## Test plan
- N=8, RD_LAT=1, sorter presents 1,2,3,8,12,13,22,31, `m_ready_i`=1 → `write_o` high for exactly 8 cycles; downstream sees the same 8 words in order; `m_last_o` only on 31; `done_o` single pulse; `order_err_o`=0.
- Same run with `xout_i` sequence 1,2,8,3,… → `order_err_o`=1 after capture of word 3 and stays 1. All 8 words are still streamed. A following clean run clears `order_err_o` at its start.
- Duplicates 5,5,5,5,7,7,9,9 → `order_err_o`=0.
- `m_ready_i` toggling 1,0,0,1,… during DRAIN → no word lost or duplicated; `m_data_o` stable during stalls; total handshakes = 8.
- `qcomp_i` pulsed again during REQ → `overrun_o`=1, run completes normally, no second `write_o` burst.
- `rst_n` low at the 4th `write_o` cycle → all outputs 0 asynchronously. After release, a fresh `qcomp_i` edge gives a complete correct run with RD_LAT=0 and RD_LAT=3 builds.
